// File: rtl/stream_addr_seq_pkg.sv
// Shared definitions for the stream address sequencer family.
// State encoding used by stream_addr_seq.
package stream_addr_seq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/stream_addr_step.sv
// Combinational next-address unit: addr + stride, wrapping at 2^addrN.
// With STREAM_ADDR_SEQ_LIMIT_EN the sum is folded modulo a limit (0 = no limit).
module stream_addr_step #(
   parameter int addrN = 8
) (
   input  logic [addrN-1:0] addr,
   input  logic [addrN-1:0] stride,
`ifdef STREAM_ADDR_SEQ_LIMIT_EN
   input  logic [addrN-1:0] limit,
`endif
   output logic [addrN-1:0] next_addr
);

`ifdef STREAM_ADDR_SEQ_LIMIT_EN
   logic [addrN:0] sum;
   logic [addrN:0] diff;

   // Carry bit kept so a sum past 2^addrN still compares correctly against the limit.
   always_comb begin
      sum       = {1'b0, addr} + {1'b0, stride};
      diff      = sum - {1'b0, limit};
      next_addr = sum[addrN-1:0];
      if ((limit != '0) && (sum >= {1'b0, limit}))
         next_addr = diff[addrN-1:0];
   end
`else
   always_comb begin
      next_addr = addr + stride;
   end
`endif

endmodule

// File: rtl/stream_addr_seq.sv
// Command-driven address sequencer: emits count addresses base, base+stride, ...
// then a done token. Optional modulo-limit wrap via STREAM_ADDR_SEQ_LIMIT_EN.
module stream_addr_seq
   import stream_addr_seq_pkg::*;
#(
   parameter int addrN = 8,
   parameter int cntN  = 8
) (
   input  logic             clk,
   input  logic             nrst,
   input  logic [addrN-1:0] cmd_base,
   input  logic [addrN-1:0] cmd_stride,
   input  logic [cntN-1:0]  cmd_count,
`ifdef STREAM_ADDR_SEQ_LIMIT_EN
   input  logic [addrN-1:0] cmd_limit,
`endif
   input  logic             cmd_valid,
   output logic             cmd_ready,
   output logic [addrN-1:0] addr,
   output logic             addr_valid,
   input  logic             addr_ready,
   output logic             done_valid,
   input  logic             done_ready,
   output logic             busy
);

   state_t           state, state_n;
   logic [addrN-1:0] addr_n;
   logic [addrN-1:0] stride_q, stride_n;
   logic [cntN-1:0]  rem_q, rem_n;
   logic [addrN-1:0] addr_nxt;
`ifdef STREAM_ADDR_SEQ_LIMIT_EN
   logic [addrN-1:0] limit_q, limit_n;
`endif

   stream_addr_step #(.addrN(addrN)) u_step (
      .addr      (addr),
      .stride    (stride_q),
`ifdef STREAM_ADDR_SEQ_LIMIT_EN
      .limit     (limit_q),
`endif
      .next_addr (addr_nxt)
   );

   // Valids decode from state so an asynchronous reset drops them at once.
   assign cmd_ready  = (state == IDLE);
   assign addr_valid = (state == RUN);
   assign done_valid = (state == DONE);
   assign busy       = (state != IDLE);

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state    <= IDLE;
         addr     <= '0;
         stride_q <= '0;
         rem_q    <= '0;
`ifdef STREAM_ADDR_SEQ_LIMIT_EN
         limit_q  <= '0;
`endif
      end else begin
         state    <= state_n;
         addr     <= addr_n;
         stride_q <= stride_n;
         rem_q    <= rem_n;
`ifdef STREAM_ADDR_SEQ_LIMIT_EN
         limit_q  <= limit_n;
`endif
      end
   end

   always_comb begin
      state_n  = state;
      addr_n   = addr;
      stride_n = stride_q;
      rem_n    = rem_q;
`ifdef STREAM_ADDR_SEQ_LIMIT_EN
      limit_n  = limit_q;
`endif
      case (state)
         IDLE: begin
            if (cmd_valid) begin
               addr_n   = cmd_base;
               stride_n = cmd_stride;
               rem_n    = cmd_count;
`ifdef STREAM_ADDR_SEQ_LIMIT_EN
               limit_n  = cmd_limit;
`endif
               state_n  = (cmd_count != '0) ? RUN : DONE;
            end
         end
         RUN: begin
            // Compare against 1 so a full-scale count never needs an extra bit.
            if (addr_ready) begin
               if (rem_q > cntN'(1)) begin
                  addr_n = addr_nxt;
                  rem_n  = rem_q - cntN'(1);
               end else begin
                  rem_n   = '0;
                  state_n = DONE;
               end
            end
         end
         DONE: begin
            if (done_ready)
               state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

endmodule

// File: tb/tb_stream_addr_seq.sv
// Directed self-checking bench for stream_addr_seq: command table plus
// hand-written reset, full-scale count and (optional) limit sequences.
module tb_stream_addr_seq;

   logic       clk;
   logic       nrst;
   logic [7:0] cmd_base;
   logic [7:0] cmd_stride;
   logic [7:0] cmd_count;
   logic [7:0] cmd_limit;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [7:0] addr;
   logic       addr_valid;
   logic       addr_ready;
   logic       done_valid;
   logic       done_ready;
   logic       busy;

   int total = 0;
   int bad   = 0;

   stream_addr_seq #(.addrN(8), .cntN(8)) dut (
      .clk        (clk),
      .nrst       (nrst),
      .cmd_base   (cmd_base),
      .cmd_stride (cmd_stride),
      .cmd_count  (cmd_count),
`ifdef STREAM_ADDR_SEQ_LIMIT_EN
      .cmd_limit  (cmd_limit),
`endif
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .addr       (addr),
      .addr_valid (addr_valid),
      .addr_ready (addr_ready),
      .done_valid (done_valid),
      .done_ready (done_ready),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string      name;
      logic [7:0] base;
      logic [7:0] stride;
      logic [7:0] count;
      logic [7:0] limit;
      logic [7:0] rdy_pat;
      logic [7:0] exp [8];
   } vec_t;

   vec_t vecs [5];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Issues one command, walks the address stream with the ready pattern,
   // then checks the done token is held and the return to idle.
   task automatic run_vec(input vec_t v);
      int idx;
      int cyc;
      @(negedge clk);
      cmd_base   = v.base;
      cmd_stride = v.stride;
      cmd_count  = v.count;
      cmd_limit  = v.limit;
      cmd_valid  = 1'b1;
      chk({v.name, ".cmd_ready"}, cmd_ready, 1);
      idx = 0;
      cyc = 0;
      while (idx < int'(v.count) && cyc < 64) begin
         @(negedge clk);
         cmd_valid  = 1'b0;
         addr_ready = v.rdy_pat[cyc % 8];
         chk({v.name, ".addr_valid"}, addr_valid, 1);
         chk({v.name, ".addr"}, addr, v.exp[idx]);
         if (addr_ready) idx++;
         cyc++;
      end
      chk({v.name, ".cycle_budget"}, (cyc < 64), 1);
      @(negedge clk);
      cmd_valid  = 1'b0;
      addr_ready = 1'b1;
      chk({v.name, ".done_valid"}, done_valid, 1);
      chk({v.name, ".addr_valid_off"}, addr_valid, 0);
      chk({v.name, ".cmd_ready_busy"}, cmd_ready, 0);
      @(negedge clk);
      chk({v.name, ".done_held"}, done_valid, 1);
      done_ready = 1'b1;
      @(negedge clk);
      done_ready = 1'b0;
      chk({v.name, ".done_off"}, done_valid, 0);
      chk({v.name, ".cmd_ready_back"}, cmd_ready, 1);
      chk({v.name, ".busy_off"}, busy, 0);
   endtask

   initial begin
      vecs[0] = '{"inc8",   8'h00, 8'h01, 8'd8, 8'h00, 8'hFF,
                  '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07}};
      vecs[1] = '{"stall",  8'h03, 8'h07, 8'd4, 8'h00, 8'b1101_1001,
                  '{8'h03, 8'h0A, 8'h11, 8'h18, 8'h00, 8'h00, 8'h00, 8'h00}};
      vecs[2] = '{"wrap",   8'hFE, 8'h03, 8'd3, 8'h00, 8'hFF,
                  '{8'hFE, 8'h01, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}};
      vecs[3] = '{"stride0", 8'h55, 8'h00, 8'd3, 8'h00, 8'b1010_1010,
                  '{8'h55, 8'h55, 8'h55, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}};
      vecs[4] = '{"count0", 8'h05, 8'h01, 8'd0, 8'h00, 8'hFF,
                  '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}};

      nrst       = 1'b0;
      cmd_base   = '0;
      cmd_stride = '0;
      cmd_count  = '0;
      cmd_limit  = '0;
      cmd_valid  = 1'b0;
      addr_ready = 1'b1;
      done_ready = 1'b0;
      #12;
      chk("reset.cmd_ready", cmd_ready, 1);
      chk("reset.addr_valid", addr_valid, 0);
      chk("reset.addr", addr, 0);
      chk("reset.done_valid", done_valid, 0);
      chk("reset.busy", busy, 0);
      @(negedge clk);
      nrst = 1'b1;

      for (int i = 0; i < 5; i++) run_vec(vecs[i]);

      // Reset in the middle of a run, after two addresses have been taken.
      @(negedge clk);
      cmd_base   = 8'h00;
      cmd_stride = 8'h01;
      cmd_count  = 8'd8;
      cmd_valid  = 1'b1;
      addr_ready = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      chk("rst.addr0", addr, 8'h00);
      @(negedge clk);
      chk("rst.addr1", addr, 8'h01);
      @(posedge clk);
      #2;
      nrst = 1'b0;
      #1;
      chk("rst.addr_valid_drop", addr_valid, 0);
      chk("rst.done_valid_drop", done_valid, 0);
      chk("rst.cmd_ready", cmd_ready, 1);
      @(negedge clk);
      nrst = 1'b1;
      @(negedge clk);
      chk("rst.no_done", done_valid, 0);
      chk("rst.idle", busy, 0);
      begin
         vec_t v;
         v = '{"after_rst", 8'h40, 8'h01, 8'd2, 8'h00, 8'hFF,
               '{8'h40, 8'h41, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}};
         run_vec(v);
      end

      // Full-scale count: 255 addresses back to back, base 0x10 stride 1.
      begin
         int n;
         logic [7:0] exp_a;
         @(negedge clk);
         cmd_base   = 8'h10;
         cmd_stride = 8'h01;
         cmd_count  = 8'd255;
         cmd_valid  = 1'b1;
         addr_ready = 1'b1;
         n = 0;
         exp_a = 8'h10;
         @(negedge clk);
         cmd_valid = 1'b0;
         while (addr_valid && n < 300) begin
            if (addr !== exp_a) chk("max.addr", addr, exp_a);
            exp_a = exp_a + 8'h01;
            n++;
            @(negedge clk);
         end
         chk("max.count", n, 255);
         chk("max.done", done_valid, 1);
         done_ready = 1'b1;
         @(negedge clk);
         done_ready = 1'b0;
         chk("max.idle", cmd_ready, 1);
      end

`ifdef STREAM_ADDR_SEQ_LIMIT_EN
      begin
         vec_t v;
         v = '{"limit", 8'h08, 8'h03, 8'd4, 8'd10, 8'hFF,
               '{8'h08, 8'h01, 8'h04, 8'h07, 8'h00, 8'h00, 8'h00, 8'h00}};
         run_vec(v);
      end
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
